// File: rtl/boot_pkg.sv
// Shared types and constants for the byte-stream boot loader.
package boot_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        VEC_LO,
        VEC_HI,
        HOLD,
        RUN,
        ERROR
    } boot_state_t;

    localparam logic [15:0] RESET_VEC_LO       = 16'hfffc;
    localparam logic [15:0] RESET_VEC_HI       = 16'hfffd;
    localparam logic [7:0]  DEFAULT_MAGIC      = 8'hA5;
    localparam int          DEFAULT_RESET_HOLD = 10;

endpackage

// File: rtl/boot_loader.sv
// Loads a framed image from a host byte stream into memory, writes the reset
// vector, then releases the core's reset after a fixed hold time.
module boot_loader
    import boot_pkg::*;
#(
    parameter int          RESET_HOLD = DEFAULT_RESET_HOLD,
    parameter logic [7:0]  MAGIC      = DEFAULT_MAGIC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wr_data,
    output logic        mem_wr_enable,
    output logic        loading,
    output logic        proc_resetn,
    output logic        done,
    output logic        error
);

    // HOLD is entered one cycle after the fffd write, so it counts RESET_HOLD-1
    // edges; the counter runs down from RESET_HOLD-2 to zero and leaves on zero.
    localparam logic [15:0] HOLD_INIT = 16'(RESET_HOLD - 2);

    boot_state_t state_q;
    logic [15:0] addr_q;
    logic [15:0] len_q;
    logic [15:0] offset_q;
    logic [15:0] hold_q;
    logic [7:0]  sum_q;
    logic        in_ready_q;
    logic [15:0] mem_address_q;
    logic [7:0]  mem_wr_data_q;
    logic        mem_wr_enable_q;
    logic        loading_q;
    logic        proc_resetn_q;
    logic        done_q;
    logic        error_q;

    logic        accept;
    logic [7:0]  sum_d;

    assign accept = in_valid & in_ready_q;
    assign sum_d  = sum_q + in_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            addr_q          <= 16'h0000;
            len_q           <= 16'h0000;
            offset_q        <= 16'h0000;
            hold_q          <= 16'h0000;
            sum_q           <= 8'h00;
            in_ready_q      <= 1'b0;
            mem_address_q   <= 16'h0000;
            mem_wr_data_q   <= 8'h00;
            mem_wr_enable_q <= 1'b0;
            loading_q       <= 1'b1;
            proc_resetn_q   <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            mem_wr_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept && in_data == MAGIC) begin
                        sum_q   <= 8'h00;
                        state_q <= ADDR_LO;
                    end
                end
                ADDR_LO: if (accept) begin
                    addr_q[7:0] <= in_data;
                    sum_q       <= sum_d;
                    state_q     <= ADDR_HI;
                end
                ADDR_HI: if (accept) begin
                    addr_q[15:8] <= in_data;
                    sum_q        <= sum_d;
                    state_q      <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    len_q[7:0] <= in_data;
                    sum_q      <= sum_d;
                    state_q    <= LEN_HI;
                end
                LEN_HI: if (accept) begin
                    len_q[15:8] <= in_data;
                    sum_q       <= sum_d;
                    offset_q    <= 16'h0000;
                    state_q     <= ({in_data, len_q[7:0]} == 16'h0000) ? CSUM : DATA;
                end
                DATA: if (accept) begin
                    mem_address_q   <= addr_q + offset_q;
                    mem_wr_data_q   <= in_data;
                    mem_wr_enable_q <= 1'b1;
                    sum_q           <= sum_d;
                    offset_q        <= offset_q + 16'h0001;
                    if (offset_q == len_q - 16'h0001) begin
                        state_q <= CSUM;
                    end
                end
                CSUM: if (accept) begin
                    in_ready_q <= 1'b0;
                    // The low vector byte is registered here so it appears
                    // with the same one-cycle latency as a payload write.
                    if (sum_d == 8'h00) begin
                        mem_address_q   <= RESET_VEC_LO;
                        mem_wr_data_q   <= addr_q[7:0];
                        mem_wr_enable_q <= 1'b1;
                        state_q         <= VEC_LO;
                    end else begin
                        error_q <= 1'b1;
                        state_q <= ERROR;
                    end
                end
                VEC_LO: begin
                    mem_address_q   <= RESET_VEC_HI;
                    mem_wr_data_q   <= addr_q[15:8];
                    mem_wr_enable_q <= 1'b1;
                    state_q         <= VEC_HI;
                end
                VEC_HI: begin
                    hold_q  <= HOLD_INIT;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (hold_q == 16'h0000) begin
                        proc_resetn_q <= 1'b1;
                        loading_q     <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= RUN;
                    end else begin
                        hold_q <= hold_q - 16'h0001;
                    end
                end
                RUN: begin
                end
                ERROR: begin
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_address   = mem_address_q;
    assign mem_wr_data   = mem_wr_data_q;
    assign mem_wr_enable = mem_wr_enable_q;
    assign loading       = loading_q;
    assign proc_resetn   = proc_resetn_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: frames are built from the image description,
// expected memory writes are queued up front and a monitor checks the write bus.
module tb_boot_loader;

    localparam int RESET_HOLD = 10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mem_address;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_enable;
    logic        loading;
    logic        proc_resetn;
    logic        done;
    logic        error;

    boot_loader #(.RESET_HOLD(RESET_HOLD), .MAGIC(8'hA5)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_address   (mem_address),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_enable (mem_wr_enable),
        .loading       (loading),
        .proc_resetn   (proc_resetn),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cycle_cnt = 0;
    int fffd_cycle = 0;
    int run_cycle = 0;
    logic prev_prn = 1'b0;

    logic [23:0] exp_q[$];
    logic [7:0]  pl_q[$];
    logic [7:0]  gb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected {address, data}.
    always @(negedge clk) begin
        cycle_cnt++;
        if (resetn && mem_wr_enable) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got %h=%h expected no write", mem_address, mem_wr_data);
            end else begin
                check("mem_write", {8'h00, mem_address, mem_wr_data}, {8'h00, exp_q.pop_front()});
            end
            if (mem_address == 16'hfffd) fffd_cycle = cycle_cnt;
        end
        if (proc_resetn && !prev_prn) run_cycle = cycle_cnt;
        prev_prn = proc_resetn;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {26'd0, in_ready, mem_wr_enable, loading, proc_resetn, done, error},
              {26'd0, 6'b001000});
        check({tag, "_bus"}, {8'h00, mem_address, mem_wr_data}, 32'h0);
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: got in_ready=0 expected byte %h accepted", b);
        end
    endtask

    // Sends gb_q garbage, then a frame carrying pl_q at addr. abort_after >= 0 drops
    // resetn after that many payload bytes have been written.
    task automatic run_frame(input logic [15:0] addr, input bit bad,
                             input int gap_lo, input int gap_hi, input int abort_after);
        logic [7:0]  fr[$];
        logic [7:0]  s;
        logic [15:0] len;
        int          n_wr;
        int          stop_idx;
        bit          ok;
        len = 16'(pl_q.size());
        s = addr[7:0] + addr[15:8] + len[7:0] + len[15:8];
        foreach (pl_q[i]) s = s + pl_q[i];
        fr = gb_q;
        fr.push_back(8'hA5);
        fr.push_back(addr[7:0]);
        fr.push_back(addr[15:8]);
        fr.push_back(len[7:0]);
        fr.push_back(len[15:8]);
        foreach (pl_q[i]) fr.push_back(pl_q[i]);
        fr.push_back(bad ? 8'(-s + 8'd1) : 8'(-s));

        n_wr = (abort_after >= 0) ? abort_after : pl_q.size();
        for (int i = 0; i < n_wr; i++) exp_q.push_back({addr + 16'(i), pl_q[i]});
        if (abort_after < 0 && !bad) begin
            exp_q.push_back({16'hfffc, addr[7:0]});
            exp_q.push_back({16'hfffd, addr[15:8]});
        end

        stop_idx = (abort_after >= 0) ? gb_q.size() + 5 + abort_after : fr.size();
        for (int i = 0; i < stop_idx; i++) begin
            int g;
            send_byte(fr[i], ok);
            if (!ok) break;
            g = $urandom_range(gap_hi, gap_lo);
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;

        if (abort_after >= 0) begin
            @(negedge clk);
            #1;
            resetn = 1'b0;
            #1;
            check_reset_outputs("abort");
            check("abort_pending", exp_q.size(), 32'd0);
            return;
        end

        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (done || error) break;
        end
        if (bad) begin
            repeat (RESET_HOLD + 5) @(negedge clk);
            #1;
            check("bad_status", {27'd0, error, done, proc_resetn, in_ready, loading},
                  {27'd0, 5'b10001});
        end else begin
            check("good_status", {27'd0, error, done, proc_resetn, in_ready, loading},
                  {27'd0, 5'b01100});
            check("hold_cycles", run_cycle - fffd_cycle, RESET_HOLD);
        end
        check("pending_writes", exp_q.size(), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Directed: the reference image at 8000.
        gb_q = {};
        pl_q = {8'hA9, 8'h42, 8'hEA};
        run_frame(16'h8000, 1'b0, 0, 0, -1);

        do_reset();
        run_frame(16'h8000, 1'b1, 0, 0, -1);

        do_reset();
        gb_q = {8'h00, 8'hFF, 8'h13};
        run_frame(16'h8000, 1'b0, 0, 0, -1);
        gb_q = {};

        do_reset();
        pl_q = {8'h11, 8'h22, 8'h33};
        run_frame(16'hfffe, 1'b0, 0, 0, -1);

        do_reset();
        pl_q = {8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(16'hfffa, 1'b0, 0, 0, -1);

        do_reset();
        pl_q = {};
        run_frame(16'h1234, 1'b0, 0, 0, -1);

        do_reset();
        pl_q = {8'h5A, 8'hC3, 8'h7E, 8'h01, 8'h99};
        run_frame(16'h0400, 1'b0, 1, 1, -1);

        do_reset();
        pl_q = {8'hA9, 8'h42, 8'hEA};
        run_frame(16'h8000, 1'b0, 0, 0, 1);
        do_reset();
        run_frame(16'h8000, 1'b0, 0, 0, -1);

        for (int k = 0; k < 12; k++) begin
            int n;
            do_reset();
            gb_q = {};
            n = $urandom_range(3, 0);
            for (int i = 0; i < n; i++) begin
                logic [7:0] g;
                g = 8'($urandom_range(255, 0));
                gb_q.push_back((g == 8'hA5) ? 8'h00 : g);
            end
            pl_q = {};
            n = $urandom_range(8, 0);
            for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(255, 0)));
            run_frame(16'($urandom), ($urandom_range(3, 0) == 0), 0, $urandom_range(2, 0), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
